// File: rtl/spi_ram_burst.sv
// Single-port RAM behind an SPI slave: executes 2-bit-tagged command words with
// independent auto-incrementing write/read pointers and an error pulse on bad commands.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  localparam logic [1:0] TAG_WR_ADDR = 2'b00;
  localparam logic [1:0] TAG_WR_DATA = 2'b01;
  localparam logic [1:0] TAG_RD_ADDR = 2'b10;
  localparam logic [1:0] TAG_RD_DATA = 2'b11;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_wr_armed;
  logic              r_rd_armed;
  logic [DATA_W-1:0] r_dout;
  logic              r_tx_valid;
  logic              r_err;

  logic [1:0]        w_tag;
  logic [DATA_W-1:0] w_payload;
  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic              w_mem_we;

  assign w_tag     = din[DATA_W+1:DATA_W];
  assign w_payload = din[DATA_W-1:0];
  assign w_addr    = din[ADDR_W-1:0];
  // One extra bit so MEM_DEPTH == 2**ADDR_W compares correctly.
  assign w_addr_ok = ({1'b0, w_addr} < (ADDR_W+1)'(MEM_DEPTH));

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if (AUTO_INC == 0)
      return p;
    else if (p == ADDR_W'(MEM_DEPTH - 1))
      return '0;
    else
      return p + 1'b1;
  endfunction

  assign w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
  assign w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
  assign w_mem_we     = rx_valid && (w_tag == TAG_WR_DATA) && r_wr_armed;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= w_payload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_armed <= 1'b0;
      r_rd_armed <= 1'b0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
      if (rx_valid) begin
        case (w_tag)
          TAG_WR_ADDR: begin
            if (w_addr_ok) begin
              r_wr_ptr   <= w_addr;
              r_wr_armed <= 1'b1;
            end else begin
              r_wr_armed <= 1'b0;
              r_err      <= 1'b1;
            end
          end
          TAG_WR_DATA: begin
            if (r_wr_armed) r_wr_ptr <= w_wr_ptr_nxt;
            else            r_err    <= 1'b1;
          end
          TAG_RD_ADDR: begin
            if (w_addr_ok) begin
              r_rd_ptr   <= w_addr;
              r_rd_armed <= 1'b1;
            end else begin
              r_rd_armed <= 1'b0;
              r_err      <= 1'b1;
            end
          end
          TAG_RD_DATA: begin
            if (r_rd_armed) begin
              r_dout     <= r_mem[r_rd_ptr];
              r_tx_valid <= 1'b1;
              r_rd_ptr   <= w_rd_ptr_nxt;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign err      = r_err;

endmodule
